// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared enums and field widths for the FE/BE adapter and its peers.
package bp_be_pkg;
  localparam int fe_cmd_opcode_width_gp = 3;
  localparam int fe_cmd_subop_width_gp = 2;
  typedef enum logic [1:0] {e_run, e_redirect, e_fence} adapter_state_e;
  typedef enum logic {e_fe_fetch = 1'b0, e_fe_exception = 1'b1} fe_msg_type_e;
  typedef enum logic [2:0] {
    e_op_state_reset    = 3'd0,
    e_op_pc_redirection = 3'd1,
    e_op_icache_fence   = 3'd2,
    e_op_attaboy        = 3'd3,
    e_op_itlb_fill      = 3'd4
  } fe_cmd_opcode_e;
  typedef enum logic [1:0] {
    e_subop_none              = 2'd0,
    e_subop_branch_mispredict = 2'd1,
    e_subop_trap              = 2'd2,
    e_subop_eret              = 2'd3
  } fe_cmd_subop_e;
endpackage

// File: rtl/bp_be_fe_queue_fifo.sv
// bp_be_fe_queue_fifo: valid/ready FIFO with synchronous flush taking priority over enqueue.
module bp_be_fe_queue_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 8,
  localparam int ptr_w_lp = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rd, r_wr;
  logic [ptr_w_lp:0] r_cnt;
  logic w_enq, w_deq;
  assign ready_o = r_cnt != (ptr_w_lp+1)'(els_p);
  assign v_o = r_cnt != '0;
  assign data_o = r_mem[r_rd];
  assign w_enq = v_i & ready_o;
  assign w_deq = yumi_i & v_o;
  always_ff @(posedge clk_i)
    if (reset_i | flush_i) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + ptr_w_lp'(w_enq);
      r_rd <= r_rd + ptr_w_lp'(w_deq);
      r_cnt <= r_cnt + (ptr_w_lp+1)'(w_enq) - (ptr_w_lp+1)'(w_deq);
    end
  always_ff @(posedge clk_i)
    if (w_enq) r_mem[r_wr] <= data_i;
endmodule

// File: rtl/bp_be_fe_adapter.sv
// bp_be_fe_adapter: BE endpoint of the FE/BE link; buffers fe_queue entries for issue
// and turns branch resolutions and fences into fe_cmd packets.
module bp_be_fe_adapter
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int paddr_width_p = 56,
  parameter int asid_width_p = 10,
  parameter int btb_indx_width_p = 9,
  parameter int bht_indx_width_p = 6,
  parameter int ras_addr_width_p = 2,
  parameter int instr_width_p = 32,
  parameter int fe_queue_els_p = 8,
  localparam int branch_metadata_fwd_width_lp = btb_indx_width_p + bht_indx_width_p + ras_addr_width_p,
  localparam int fe_queue_width_lp = 1 + vaddr_width_p + instr_width_p + branch_metadata_fwd_width_lp,
  localparam int fe_cmd_width_lp = fe_cmd_opcode_width_gp + vaddr_width_p + fe_cmd_subop_width_gp
                                   + branch_metadata_fwd_width_lp + paddr_width_p + asid_width_p
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [fe_queue_width_lp-1:0]            fe_queue_i,
  input  logic                                    fe_queue_v_i,
  output logic                                    fe_queue_ready_o,
  output logic [fe_cmd_width_lp-1:0]              fe_cmd_o,
  output logic                                    fe_cmd_v_o,
  input  logic                                    fe_cmd_ready_i,
  output logic [vaddr_width_p-1:0]                issue_pc_o,
  output logic [instr_width_p-1:0]                issue_instr_o,
  output logic [branch_metadata_fwd_width_lp-1:0] issue_metadata_o,
  output logic                                    issue_exc_v_o,
  output logic                                    issue_v_o,
  input  logic                                    issue_yumi_i,
  input  logic                                    br_resolve_v_i,
  input  logic                                    br_mispredict_i,
  input  logic [vaddr_width_p-1:0]                br_pc_i,
  input  logic [vaddr_width_p-1:0]                br_target_i,
  input  logic [branch_metadata_fwd_width_lp-1:0] br_metadata_i,
  input  logic                                    fence_v_i,
  output logic                                    fence_ready_o
);
  localparam int md_w_lp = branch_metadata_fwd_width_lp;
  adapter_state_e r_state, w_state_n;
  fe_cmd_opcode_e r_cmd_op, w_cmd_op_n;
  fe_cmd_subop_e r_cmd_sub, w_cmd_sub_n;
  logic [vaddr_width_p-1:0] r_cmd_pc, w_cmd_pc_n;
  logic [md_w_lp-1:0] r_cmd_md, w_cmd_md_n;
  logic r_cmd_v, w_cmd_v_n;
  logic [fe_queue_width_lp-1:0] w_head;
  logic w_fifo_ready, w_fifo_v, w_run, w_mispredict, w_fence_acc, w_attaboy, w_cmd_deq;
  assign w_run = r_state == e_run;
  assign w_mispredict = br_resolve_v_i & br_mispredict_i;
  assign w_cmd_deq = r_cmd_v & fe_cmd_ready_i;
  assign fence_ready_o = ~reset_i & w_run & ~r_cmd_v & ~w_mispredict;
  assign w_fence_acc = fence_v_i & fence_ready_o;
  // Attaboys are advisory: only taken when the command slot is free this cycle.
  assign w_attaboy = br_resolve_v_i & ~br_mispredict_i & w_run & (~r_cmd_v | fe_cmd_ready_i);
  assign fe_queue_ready_o = ~reset_i & w_run & w_fifo_ready;
  assign issue_v_o = ~reset_i & w_run & w_fifo_v;
  assign fe_cmd_v_o = ~reset_i & r_cmd_v;
  assign fe_cmd_o = {r_cmd_op, r_cmd_pc, r_cmd_sub, r_cmd_md, {(paddr_width_p+asid_width_p){1'b0}}};
  assign issue_exc_v_o = fe_msg_type_e'(w_head[fe_queue_width_lp-1]) != e_fe_fetch;
  assign issue_pc_o = w_head[instr_width_p+md_w_lp +: vaddr_width_p];
  assign issue_instr_o = issue_exc_v_o ? '0 : w_head[md_w_lp +: instr_width_p];
  assign issue_metadata_o = w_head[md_w_lp-1:0];
  bp_be_fe_queue_fifo #(
    .width_p(fe_queue_width_lp),
    .els_p  (fe_queue_els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .flush_i(w_mispredict | w_fence_acc),
    .v_i    (fe_queue_v_i & fe_queue_ready_o),
    .data_i (fe_queue_i),
    .ready_o(w_fifo_ready),
    .v_o    (w_fifo_v),
    .data_o (w_head),
    .yumi_i (issue_yumi_i & issue_v_o)
  );
  always_ff @(posedge clk_i)
    if (reset_i) begin
      r_state <= e_run;
      r_cmd_v <= 1'b0;
      r_cmd_op <= e_op_state_reset;
      r_cmd_sub <= e_subop_none;
      r_cmd_pc <= '0;
      r_cmd_md <= '0;
    end else begin
      r_state <= w_state_n;
      r_cmd_v <= w_cmd_v_n;
      r_cmd_op <= w_cmd_op_n;
      r_cmd_sub <= w_cmd_sub_n;
      r_cmd_pc <= w_cmd_pc_n;
      r_cmd_md <= w_cmd_md_n;
    end
  always_comb begin
    w_state_n = r_state;
    w_cmd_v_n = r_cmd_v & ~fe_cmd_ready_i;
    w_cmd_op_n = r_cmd_op;
    w_cmd_sub_n = r_cmd_sub;
    w_cmd_pc_n = r_cmd_pc;
    w_cmd_md_n = r_cmd_md;
    if (w_mispredict) begin
      w_state_n = e_redirect;
      w_cmd_v_n = 1'b1;
      w_cmd_op_n = e_op_pc_redirection;
      w_cmd_sub_n = e_subop_branch_mispredict;
      w_cmd_pc_n = br_target_i;
      w_cmd_md_n = br_metadata_i;
    end else if (w_fence_acc) begin
      w_state_n = e_fence;
      w_cmd_v_n = 1'b1;
      w_cmd_op_n = e_op_icache_fence;
      w_cmd_sub_n = e_subop_none;
      w_cmd_pc_n = '0;
      w_cmd_md_n = '0;
    end else begin
      if (w_attaboy) begin
        w_cmd_v_n = 1'b1;
        w_cmd_op_n = e_op_attaboy;
        w_cmd_sub_n = e_subop_none;
        w_cmd_pc_n = br_pc_i;
        w_cmd_md_n = br_metadata_i;
      end
      if (!w_run && w_cmd_deq) w_state_n = e_run;
    end
  end
endmodule

// File: tb/tb_bp_be_fe_adapter.sv
// tb_bp_be_fe_adapter: directed vectors plus hand sequences for redirect, attaboy, fence and reset.
module tb_bp_be_fe_adapter;
  import bp_be_pkg::*;
  localparam int V = 39, M = 17, QW = 1 + V + 32 + M, CW = 3 + V + 2 + M + 66;
  typedef struct packed {
    logic [2:0]   op;
    logic [V-1:0] pc;
    logic [1:0]   sub;
    logic [M-1:0] md;
    logic [65:0]  pad;
  } cmd_t;
  typedef struct {
    logic         fe_v;
    logic [V-1:0] pc;
    logic         yumi;
    logic         exp_ready;
    logic         exp_v;
    logic [V-1:0] exp_pc;
  } vec_t;
  logic clk = 0, reset_i;
  logic [QW-1:0] fe_queue_i;
  logic fe_queue_v_i, fe_queue_ready_o, fe_cmd_v_o, fe_cmd_ready_i;
  logic [CW-1:0] fe_cmd_o;
  logic [V-1:0] issue_pc_o, br_pc_i, br_target_i;
  logic [31:0] issue_instr_o;
  logic [M-1:0] issue_metadata_o, br_metadata_i;
  logic issue_exc_v_o, issue_v_o, issue_yumi_i, br_resolve_v_i, br_mispredict_i, fence_v_i, fence_ready_o;
  cmd_t w_cmd;
  int checks = 0, errors = 0, delivered = 0, d0;
  vec_t vecs [18];
  assign w_cmd = fe_cmd_o;
  always #5 clk = ~clk;
  always @(negedge clk) if (!reset_i && fe_cmd_v_o && fe_cmd_ready_i) delivered++;
  bp_be_fe_adapter dut (
    .clk_i(clk), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_cmd_o(fe_cmd_o), .fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_ready_i(fe_cmd_ready_i),
    .issue_pc_o(issue_pc_o), .issue_instr_o(issue_instr_o), .issue_metadata_o(issue_metadata_o),
    .issue_exc_v_o(issue_exc_v_o), .issue_v_o(issue_v_o), .issue_yumi_i(issue_yumi_i),
    .br_resolve_v_i(br_resolve_v_i), .br_mispredict_i(br_mispredict_i), .br_pc_i(br_pc_i),
    .br_target_i(br_target_i), .br_metadata_i(br_metadata_i),
    .fence_v_i(fence_v_i), .fence_ready_o(fence_ready_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [QW-1:0] fetch(input logic [V-1:0] pc);
    return {1'b0, pc, 32'h00000013 ^ 32'(pc), M'(pc)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    fe_queue_i = '0; fe_queue_v_i = 0; fe_cmd_ready_i = 0; issue_yumi_i = 0;
    br_resolve_v_i = 0; br_mispredict_i = 0; br_pc_i = '0; br_target_i = '0;
    br_metadata_i = '0; fence_v_i = 0;
  endtask
  task automatic enq(input logic [V-1:0] pc);
    fe_queue_v_i = 1; fe_queue_i = fetch(pc);
    step();
    fe_queue_v_i = 0;
  endtask
  task automatic resolve(input logic mis, input logic [V-1:0] pc);
    br_resolve_v_i = 1; br_mispredict_i = mis; br_pc_i = pc; br_target_i = pc; br_metadata_i = M'(17'h1abc);
  endtask
  initial begin
    for (int i = 0; i < 18; i++) begin
      vecs[i].fe_v = i < 9;
      vecs[i].pc = V'(32'h80000000 + 4 * i);
      vecs[i].yumi = i >= 9 && i < 17;
      vecs[i].exp_ready = i != 8 && i != 9;
      vecs[i].exp_v = i >= 1 && i < 17;
      vecs[i].exp_pc = i < 9 ? V'(32'h80000000) : V'(32'h80000000 + 4 * (i - 9));
    end
    idle();
    reset_i = 1;
    #1;
    chk("rst_qready", fe_queue_ready_o, 0);
    chk("rst_fready", fence_ready_o, 0);
    chk("rst_issue_v", issue_v_o, 0);
    chk("rst_cmd_v", fe_cmd_v_o, 0);
    step(); step();
    reset_i = 0;
    #1;
    chk("post_rst_qready", fe_queue_ready_o, 1);
    chk("post_rst_fready", fence_ready_o, 1);
    chk("post_rst_issue_v", issue_v_o, 0);
    // Fill to full with yumi low, then drain one per cycle.
    for (int i = 0; i < 18; i++) begin
      fe_queue_v_i = vecs[i].fe_v; fe_queue_i = fetch(vecs[i].pc); issue_yumi_i = vecs[i].yumi;
      #1;
      chk($sformatf("vec%0d_qready", i), fe_queue_ready_o, vecs[i].exp_ready);
      chk($sformatf("vec%0d_issue_v", i), issue_v_o, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("vec%0d_pc", i), issue_pc_o, vecs[i].exp_pc);
      step();
    end
    idle();
    // Mispredict with 5 buffered entries, held redirect, replaced by a second mispredict.
    for (int k = 0; k < 5; k++) enq(V'(32'h80000300 + 4 * k));
    #1;
    chk("pre_mis_issue_v", issue_v_o, 1);
    chk("pre_mis_pc", issue_pc_o, 39'h80000300);
    d0 = delivered;
    resolve(1, V'(32'h80000100)); issue_yumi_i = 1;
    #1;
    chk("mis_fready", fence_ready_o, 0);
    step();
    idle();
    fe_queue_v_i = 1; fe_queue_i = fetch(V'(32'h80000999));
    #1;
    chk("redir_issue_v", issue_v_o, 0);
    chk("redir_qready", fe_queue_ready_o, 0);
    chk("redir_cmd_v", fe_cmd_v_o, 1);
    chk("redir_op", w_cmd.op, e_op_pc_redirection);
    chk("redir_sub", w_cmd.sub, e_subop_branch_mispredict);
    chk("redir_pc", w_cmd.pc, 39'h80000100);
    chk("redir_md", w_cmd.md, 17'h1abc);
    chk("redir_pad", w_cmd.pad, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("hold%0d_pc", k), w_cmd.pc, 39'h80000100);
      chk($sformatf("hold%0d_v", k), fe_cmd_v_o, 1);
    end
    resolve(1, V'(32'h80000200));
    step();
    br_resolve_v_i = 0; br_mispredict_i = 0;
    #1;
    chk("mis2_pc", w_cmd.pc, 39'h80000200);
    fe_cmd_ready_i = 1;
    step();
    fe_cmd_ready_i = 0;
    #1;
    chk("deliv_cmd_v", fe_cmd_v_o, 0);
    chk("deliv_count", 64'(delivered - d0), 1);
    chk("deliv_qready", fe_queue_ready_o, 1);
    chk("deliv_issue_v", issue_v_o, 0);
    step();
    fe_queue_v_i = 0;
    #1;
    chk("post_redir_v", issue_v_o, 1);
    chk("post_redir_pc", issue_pc_o, 39'h80000999);
    chk("post_redir_exc", issue_exc_v_o, 0);
    issue_yumi_i = 1; fe_queue_v_i = 1; fe_queue_i = {1'b1, V'(32'h80000abc), 32'hdeadbeef, M'(0)};
    step();
    issue_yumi_i = 0; fe_queue_v_i = 0;
    #1;
    chk("exc_v", issue_exc_v_o, 1);
    chk("exc_pc", issue_pc_o, 39'h80000abc);
    chk("exc_instr", issue_instr_o, 0);
    issue_yumi_i = 1;
    step();
    issue_yumi_i = 0;
    // Attaboys: second one dropped while the slot is held, then loaded while emptying.
    resolve(0, V'(32'h80000040));
    step();
    resolve(0, V'(32'h80000080));
    #1;
    chk("ab_v", fe_cmd_v_o, 1);
    chk("ab_op", w_cmd.op, e_op_attaboy);
    chk("ab_pc", w_cmd.pc, 39'h80000040);
    step();
    br_resolve_v_i = 0;
    #1;
    chk("ab_drop_pc", w_cmd.pc, 39'h80000040);
    resolve(0, V'(32'h80000080)); fe_cmd_ready_i = 1;
    step();
    br_resolve_v_i = 0;
    #1;
    chk("ab_refill_v", fe_cmd_v_o, 1);
    chk("ab_refill_pc", w_cmd.pc, 39'h80000080);
    step();
    fe_cmd_ready_i = 0;
    #1;
    chk("ab_empty_v", fe_cmd_v_o, 0);
    // Mispredict beats a simultaneous fence; a later fence flushes the buffer.
    enq(V'(32'h80000400)); enq(V'(32'h80000404));
    resolve(1, V'(32'h80000500)); fence_v_i = 1;
    #1;
    chk("mf_fready", fence_ready_o, 0);
    step();
    idle();
    #1;
    chk("mf_op", w_cmd.op, e_op_pc_redirection);
    chk("mf_pc", w_cmd.pc, 39'h80000500);
    fe_cmd_ready_i = 1;
    step();
    fe_cmd_ready_i = 0;
    #1;
    chk("mf_only_redir", fe_cmd_v_o, 0);
    enq(V'(32'h80000600)); enq(V'(32'h80000604));
    fence_v_i = 1;
    #1;
    chk("fence_ready", fence_ready_o, 1);
    step();
    fence_v_i = 0;
    #1;
    chk("fence_op", w_cmd.op, e_op_icache_fence);
    chk("fence_pc", w_cmd.pc, 0);
    chk("fence_issue_v", issue_v_o, 0);
    chk("fence_qready", fe_queue_ready_o, 0);
    chk("fence_fready", fence_ready_o, 0);
    fe_cmd_ready_i = 1;
    step();
    fe_cmd_ready_i = 0;
    #1;
    chk("fence_done_v", fe_cmd_v_o, 0);
    chk("fence_flushed", issue_v_o, 0);
    chk("fence_run_qready", fe_queue_ready_o, 1);
    // Reset with 3 buffered entries, then reset in the middle of a redirect.
    enq(V'(32'h80000700)); enq(V'(32'h80000704)); enq(V'(32'h80000708));
    reset_i = 1;
    #1;
    chk("rst3_qready", fe_queue_ready_o, 0);
    chk("rst3_issue_v", issue_v_o, 0);
    step();
    reset_i = 0;
    #1;
    chk("rst3_empty", issue_v_o, 0);
    enq(V'(32'h80000710)); enq(V'(32'h80000714)); enq(V'(32'h80000718));
    resolve(1, V'(32'h80000800));
    step();
    idle();
    fe_queue_v_i = 1; fe_queue_i = fetch(V'(32'h80000900));
    reset_i = 1;
    #1;
    chk("rstr_cmd_v", fe_cmd_v_o, 0);
    chk("rstr_issue_v", issue_v_o, 0);
    chk("rstr_qready", fe_queue_ready_o, 0);
    chk("rstr_fready", fence_ready_o, 0);
    step();
    reset_i = 0;
    #1;
    chk("rstr_after_cmd_v", fe_cmd_v_o, 0);
    chk("rstr_after_issue_v", issue_v_o, 0);
    chk("rstr_after_qready", fe_queue_ready_o, 1);
    step();
    fe_queue_v_i = 0;
    #1;
    chk("rstr_first_v", issue_v_o, 1);
    chk("rstr_first_pc", issue_pc_o, 39'h80000900);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
